// File: rtl/mem_stage_sram.sv
// Memory stage: splits each 32-bit load/store into two 16-bit SRAM accesses and freezes
// the pipeline while they are in flight. Optional one-entry read buffer under READ_BUF_EN.
module mem_stage_sram #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        Val_Rm,
  output logic [31:0]        mem_out,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned WW = SRAM_AW - 1;
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CntMax = CW'(WAIT_CYCLES);
  // With no wait cycles there is no room for a hold cycle, so we_n stays low throughout.
  localparam bit WeLast = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_wr_q;
  logic [WW-1:0]   word_q;
  logic [31:0]     data_q;
  logic [31:0]     mem_out_q;

  logic [31:0]     offset;
  logic [WW-1:0]   word;
  logic            req;
  logic            hit;
  logic            start;
  logic            phase_end;
  logic            in_phase;

  assign offset = ALU_result - BASE_ADDR;
  assign word   = offset[WW+1:2];

  logic unused_offset;
  assign unused_offset = ^{offset[31:WW+2], offset[1:0]};

`ifdef READ_BUF_EN
  logic            buf_valid_q;
  logic [WW-1:0]   buf_word_q;
  logic [31:0]     buf_data_q;

  assign hit = (state_q == StIdle) & MEM_R_EN & ~MEM_W_EN & buf_valid_q & (buf_word_q == word);
`else
  assign hit = 1'b0;
`endif

  assign req       = MEM_R_EN | MEM_W_EN;
  assign start     = (state_q == StIdle) & req & ~hit;
  assign phase_end = (cnt_q == CntMax);
  assign in_phase  = (state_q == StLo) | (state_q == StHi);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StLo;
      StLo: begin
        cnt_d = phase_end ? '0 : cnt_q + 1'b1;
        if (phase_end) state_d = StHi;
      end
      StHi: begin
        cnt_d = phase_end ? '0 : cnt_q + 1'b1;
        if (phase_end) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      word_q    <= '0;
      data_q    <= '0;
      mem_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        is_wr_q <= MEM_W_EN;
        word_q  <= word;
        data_q  <= Val_Rm;
      end
      if (~is_wr_q & phase_end & (state_q == StLo)) mem_out_q[15:0]  <= sram_dq_i;
      if (~is_wr_q & phase_end & (state_q == StHi)) mem_out_q[31:16] <= sram_dq_i;
`ifdef READ_BUF_EN
      if (hit) mem_out_q <= buf_data_q;
`endif
    end
  end

`ifdef READ_BUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      if (start & MEM_W_EN & buf_valid_q & (buf_word_q == word)) begin
        buf_data_q <= Val_Rm;
      end
      // Load completing: high half arrives now, low half is already in mem_out_q.
      if (~is_wr_q & phase_end & (state_q == StHi)) begin
        buf_valid_q <= 1'b1;
        buf_word_q  <= word_q;
        buf_data_q  <= {sram_dq_i, mem_out_q[15:0]};
      end
    end
  end

  assign mem_out = hit ? buf_data_q : mem_out_q;
`else
  assign mem_out = mem_out_q;
`endif

  assign ready = ((state_q == StIdle) & ~(req & ~hit)) | (state_q == StDone);

  always_comb begin
    sram_addr  = {word_q, state_q == StHi};
    sram_dq_oe = in_phase & is_wr_q;
    sram_dq_o  = '0;
    if (sram_dq_oe) sram_dq_o = (state_q == StHi) ? data_q[31:16] : data_q[15:0];
    sram_we_n  = ~(in_phase & is_wr_q & (~phase_end | WeLast));
    sram_oe_n  = ~(in_phase & ~is_wr_q);
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Scoreboard bench for mem_stage_sram: a word-level reference model predicts each transaction,
// a monitor compares data, freeze length and SRAM activity when the stage releases ready.
module tb_mem_stage_sram;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;
  localparam int unsigned AW   = 18;
  localparam int unsigned WMSK = (1 << (AW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   ALU_result, Val_Rm;
  logic [31:0]   mem_out;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, sram_we_n, sram_oe_n;

  mem_stage_sram #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_result(ALU_result), .Val_Rm(Val_Rm), .mem_out(mem_out), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: halfword array, write on rising edge while we_n is low.
  logic [15:0] sram_mem [0:(1<<AW)-1];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_o;
  assign sram_dq_i = sram_oe_n ? 16'h0 : sram_mem[sram_addr];

  // Reference model state: whole words plus the optional read buffer.
  logic [31:0] ref_mem [0:WMSK];
  bit          rb_valid;
  int unsigned rb_word;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          frz;
    int          n_oe;
    int          n_we;
    int          n_dqoe;
    logic [31:0] a_first;
    logic [31:0] a_last;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one pipeline request, push its predicted outcome, hold it until ready releases it.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data);
    exp_t        e;
    int unsigned w;
    bit          hit;
    int          cnt;
    w   = ((addr - BASE) >> 2) & WMSK;
    hit = 1'b0;
    e.a_first = 32'(w * 2);
    e.a_last  = 32'(w * 2 + 1);
    e.data    = '0;
    if (wr) begin
      ref_mem[w] = data;
      e.is_load = 1'b0;
      e.frz     = 2 * (W + 1) + 1;
      e.n_oe    = 0;
      e.n_we    = 2 * ((W == 0) ? 1 : W);
      e.n_dqoe  = 2 * (W + 1);
    end else begin
`ifdef READ_BUF_EN
      hit = rb_valid && (rb_word == w);
      rb_valid = 1'b1;
      rb_word  = w;
`endif
      e.is_load = 1'b1;
      e.data    = ref_mem[w];
      e.frz     = hit ? 0 : 2 * (W + 1) + 1;
      e.n_oe    = hit ? 0 : 2 * (W + 1);
      e.n_we    = 0;
      e.n_dqoe  = 0;
    end
    exp_q.push_back(e);
    MEM_R_EN = rd; MEM_W_EN = wr; ALU_result = addr; Val_Rm = data;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (ready) break;
      cnt++;
      if (cnt > 50) begin
        n_checks++;
        $display("FAIL ready_timeout: got ready=0 after %0d cycles, expected release", cnt);
        break;
      end
    end
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  // Monitor: accumulate per-transaction activity, compare when the stage releases the pipeline.
  initial begin
    int          frz, n_oe, n_we, n_dqoe;
    logic [31:0] a_first, a_last;
    bit          seen;
    exp_t        e;
    frz = 0; n_oe = 0; n_we = 0; n_dqoe = 0; seen = 0; a_first = '0; a_last = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        frz = 0; n_oe = 0; n_we = 0; n_dqoe = 0; seen = 0;
      end else if (MEM_R_EN | MEM_W_EN) begin
        if (!sram_oe_n || sram_dq_oe) begin
          if (!seen) a_first = 32'(sram_addr);
          a_last = 32'(sram_addr);
          seen = 1'b1;
        end
        if (!sram_oe_n) n_oe++;
        if (!sram_we_n) n_we++;
        if (sram_dq_oe) n_dqoe++;
        if (!ready) frz++;
        else begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_completion: got a release, expected none pending");
          end else begin
            e = exp_q.pop_front();
            if (e.is_load) check("load_data", mem_out, e.data);
            check("freeze_cycles", frz, e.frz);
            check("oe_cycles", n_oe, e.n_oe);
            check("we_cycles", n_we, e.n_we);
            check("dq_oe_cycles", n_dqoe, e.n_dqoe);
            if (e.n_oe + e.n_dqoe > 0) begin
              check("addr_low_half", a_first, e.a_first);
              check("addr_high_half", a_last, e.a_last);
            end
          end
          frz = 0; n_oe = 0; n_we = 0; n_dqoe = 0; seen = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    int unsigned w;
    logic [31:0] addr;
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    for (int i = 0; i <= int'(WMSK); i++) ref_mem[i] = '0;
    rb_valid = 1'b0; rb_word = 0;
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_result = '0; Val_Rm = '0;
    idle(3);
    rst = 1'b0;
    #2;
    check("reset_mem_out", mem_out, 32'h0);
    check("reset_ready", ready, 1'b1);
    check("reset_addr", sram_addr, '0);
    check("reset_dq_o", sram_dq_o, 16'h0);
    check("reset_dq_oe", sram_dq_oe, 1'b0);
    check("reset_we_n", sram_we_n, 1'b1);
    check("reset_oe_n", sram_oe_n, 1'b1);
    idle(1);

    // Abort a store to word 4 during its first high-half cycle.
    MEM_W_EN = 1'b1; ALU_result = BASE + 16; Val_Rm = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #2;
    check("abort_in_high_half_addr", sram_addr, 18'd9);
    check("abort_in_high_half_we_n", sram_we_n, 1'b0);
    #1;
    rst = 1'b1; MEM_W_EN = 1'b0;
    #1;
    check("abort_we_n", sram_we_n, 1'b1);
    check("abort_dq_oe", sram_dq_oe, 1'b0);
    check("abort_ready", ready, 1'b1);
    rb_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("after_abort_ready", ready, 1'b1);
    idle(1);
    do_op(1'b0, 1'b1, BASE + 16, 32'h11112222);   // resynchronise word 4

    do_op(1'b1, 1'b0, BASE, '0);
    do_op(1'b0, 1'b1, BASE + 4, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, BASE + 4, '0);
    do_op(1'b1, 1'b1, BASE + 8, 32'h12345678);
    do_op(1'b1, 1'b0, BASE + 8, '0);
    do_op(1'b1, 1'b0, BASE, '0);
    do_op(1'b1, 1'b0, BASE + 4, '0);
    do_op(1'b1, 1'b0, BASE + 4, '0);
    do_op(1'b0, 1'b1, BASE + 4, 32'h0BADF00D);
    do_op(1'b1, 1'b0, BASE + 4, '0);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      w = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0:       addr = BASE + 4 * w + (32'd1 << (AW + 1));   // wraps onto the same word
        1:       addr = BASE - 4;                              // wraps to the top word
        default: addr = BASE + 4 * w + $urandom_range(0, 3);
      endcase
      if (r < 5)      do_op(1'b1, 1'b0, addr, $urandom);
      else if (r < 8) do_op(1'b0, 1'b1, addr, $urandom);
      else            do_op(1'b1, 1'b1, addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
